// File: rtl/dma_channel_sequencer.sv
// DMA bus-cycle sequencer: arbitrates NUM_CH channels and runs the S0..S4 bus cycle,
// counting words down to terminal count and reporting write-backs to the register file.
module dma_channel_sequencer #(
    parameter int NUM_CH = 4,
    parameter int WC_W   = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_CH-1:0]         dreq,
    input  logic [NUM_CH-1:0]         chan_mask,
    input  logic [2*NUM_CH-1:0]       chan_type,
    input  logic [NUM_CH-1:0]         chan_block,
    input  logic [WC_W*NUM_CH-1:0]    wc_load,
    input  logic                      cmd_disable,
    input  logic                      cmd_rot_pri,
    input  logic                      cmd_compress,
    input  logic                      cmd_ext_wr,
    input  logic                      hlda,
    input  logic                      ready,
    input  logic                      eop_n_in,
    output logic                      hrq,
    output logic [NUM_CH-1:0]         dack,
    output logic                      aen,
    output logic                      adstb,
    output logic                      ior_n,
    output logic                      iow_n,
    output logic                      memr_n,
    output logic                      memw_n,
    output logic                      eop_n_out,
    output logic                      adr_step,
    output logic                      wc_wb,
    output logic [$clog2(NUM_CH)-1:0] wc_wb_ch,
    output logic [WC_W-1:0]           wc_wb_val,
    output logic [NUM_CH-1:0]         tc_status
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} stateType;

    stateType          state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   lastServed;
    logic [WC_W-1:0]   curWc;
    logic [NUM_CH-1:0] tcStatus;
    logic [1:0]        xferType;
    logic              blockMode;
    logic              compress;
    logic              extWr;
    logic              eopSeen;

    logic [NUM_CH-1:0] valid;
    logic [CH_W-1:0]   fixedPick;
    logic [CH_W-1:0]   rotPick;
    logic [CH_W-1:0]   pick;
    logic              onBus;

    assign valid = dreq & ~chan_mask & {NUM_CH{~cmd_disable}};
    assign onBus = (state == S1) || (state == S2) || (state == S3) ||
                   (state == SW) || (state == S4);

    // Loops run downward so the last hit is the highest-priority candidate.
    always_comb begin
        int idx;
        idx       = 0;
        fixedPick = '0;
        rotPick   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i]) fixedPick = CH_W'(i);
        end
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(lastServed) + k) % NUM_CH;
            if (valid[idx]) rotPick = CH_W'(idx);
        end
        pick = cmd_rot_pri ? rotPick : fixedPick;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= SI;
            grant      <= '0;
            lastServed <= CH_W'(NUM_CH - 1);
            curWc      <= '0;
            tcStatus   <= '0;
            xferType   <= 2'b00;
            blockMode  <= 1'b0;
            compress   <= 1'b0;
            extWr      <= 1'b0;
            eopSeen    <= 1'b0;
        end else if (onBus && !hlda) begin
            state      <= SI;
            lastServed <= grant;
        end else begin
            case (state)
                SI: begin
                    if (|valid) begin
                        state     <= S0;
                        grant     <= pick;
                        curWc     <= wc_load[int'(pick)*WC_W +: WC_W];
                        xferType  <= chan_type[int'(pick)*2 +: 2];
                        blockMode <= chan_block[pick];
                        compress  <= cmd_compress;
                        extWr     <= cmd_ext_wr;
                        eopSeen   <= 1'b0;
                    end
                end
                S0: begin
                    if (hlda) state <= S1;
                end
                S1: state <= S2;
                S2: begin
                    if (!eop_n_in) eopSeen <= 1'b1;
                    if (compress) state <= ready ? S4 : SW;
                    else          state <= S3;
                end
                S3, SW: begin
                    if (!eop_n_in) eopSeen <= 1'b1;
                    state <= ready ? S4 : SW;
                end
                S4: begin
                    curWc <= curWc - WC_W'(1);
                    if (curWc == '0) begin
                        tcStatus[grant] <= 1'b1;
                        state           <= SI;
                        lastServed      <= grant;
                    end else if (eopSeen || !eop_n_in || !blockMode) begin
                        state      <= SI;
                        lastServed <= grant;
                    end else begin
                        state <= S1;
                    end
                end
                default: state <= SI;
            endcase
        end
    end

    // Strobes and pulses are qualified by hlda so a lost bus releases them without waiting a cycle.
    always_comb begin
        logic readPh;
        logic writePh;
        readPh  = hlda && ((state == S2) || (state == S3) || (state == SW));
        writePh = hlda && ((state == S3) || (state == SW) ||
                           ((state == S2) && (extWr || compress)));
        hrq       = (state != SI);
        aen       = onBus;
        adstb     = (state == S1);
        dack      = onBus ? (NUM_CH'(1) << grant) : '0;
        ior_n     = !(readPh  && (xferType == 2'b01));
        memr_n    = !(readPh  && (xferType == 2'b10));
        memw_n    = !(writePh && (xferType == 2'b01));
        iow_n     = !(writePh && (xferType == 2'b10));
        adr_step  = hlda && (state == S4);
        wc_wb     = hlda && (state == S4);
        eop_n_out = !(hlda && (state == S4) && (curWc == '0));
        wc_wb_ch  = grant;
        wc_wb_val = curWc - WC_W'(1);
        tc_status = tcStatus;
    end

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Directed bench for dma_channel_sequencer: cycle-vector tables plus hand sequences.
module tb_dma_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dreq, chanMask, chanBlock;
    logic [7:0]  chanType;
    logic [63:0] wcLoad;
    logic        cmdDisable, cmdRotPri, cmdCompress, cmdExtWr;
    logic        hlda, ready, eopNIn;
    logic        hrq, aen, adstb, iorN, iowN, memrN, memwN, eopNOut, adrStep, wcWb;
    logic [3:0]  dack, tcStatus;
    logic [1:0]  wcWbCh;
    logic [15:0] wcWbVal;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    dma_channel_sequencer #(.NUM_CH(4), .WC_W(16)) dut (
        .CLK(clk), .RESET(rst), .dreq(dreq), .chan_mask(chanMask), .chan_type(chanType),
        .chan_block(chanBlock), .wc_load(wcLoad), .cmd_disable(cmdDisable),
        .cmd_rot_pri(cmdRotPri), .cmd_compress(cmdCompress), .cmd_ext_wr(cmdExtWr),
        .hlda(hlda), .ready(ready), .eop_n_in(eopNIn), .hrq(hrq), .dack(dack), .aen(aen),
        .adstb(adstb), .ior_n(iorN), .iow_n(iowN), .memr_n(memrN), .memw_n(memwN),
        .eop_n_out(eopNOut), .adr_step(adrStep), .wc_wb(wcWb), .wc_wb_ch(wcWbCh),
        .wc_wb_val(wcWbVal), .tc_status(tcStatus)
    );

    typedef struct packed {
        logic [3:0]  dreq;
        logic        hlda;
        logic        ready;
        logic [3:0]  expDack;
        logic        expHrq;
        logic        expAdstb;
        logic [3:0]  expStrb;   // {ior_n, iow_n, memr_n, memw_n}
        logic        expWb;
        logic        expEop;
        logic [15:0] expVal;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(logic [3:0] d, logic h, logic r, logic [3:0] dk, logic hr,
                                logic as, logic [3:0] st, logic wb, logic eo, logic [15:0] v);
        mk = '{d, h, r, dk, hr, as, st, wb, eo, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // 0: hrq=1  1: dack!=0  2: hrq=0  3: memw_n=0  4: memr_n=0  5: iow_n=0
    task automatic waitFor(input string name, input int cond);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(posedge clk); #1;
            case (cond)
                0: hit = hrq;
                1: hit = |dack;
                2: hit = !hrq;
                3: hit = !memwN;
                4: hit = !memrN;
                default: hit = !iowN;
            endcase
        end
        if (!hit) begin
            nVec++;
            nErr++;
            $display("FAIL timeout %s: got no event, expected condition %0d", name, cond);
        end
    endtask

    task automatic doReset();
        rst = 1'b1; dreq = '0; hlda = 1'b0; ready = 1'b1; eopNIn = 1'b1;
        chanMask = '0; cmdDisable = 1'b0; cmdRotPri = 1'b0; cmdCompress = 1'b0; cmdExtWr = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic runVecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            dreq  = vecs[i].dreq;
            hlda  = vecs[i].hlda;
            ready = vecs[i].ready;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  32'({hrq, dack, adstb, iorN, iowN, memrN, memwN, adrStep, wcWb, eopNOut}),
                  32'({vecs[i].expHrq, vecs[i].expDack, vecs[i].expAdstb, vecs[i].expStrb,
                       vecs[i].expWb, vecs[i].expWb, vecs[i].expEop}));
            if (vecs[i].expWb)
                check($sformatf("vec%0d_val", i), 32'({wcWbCh, wcWbVal}),
                      32'({wcWbCh, vecs[i].expVal}));
        end
    endtask

    initial begin
        // A: fixed priority, ch1 type 01 single, wc=3
        vecs[0]  = mk(4'b0110, 0, 1, 4'b0000, 1, 0, 4'b1111, 0, 1, 16'h0000);
        vecs[1]  = mk(4'b0110, 0, 1, 4'b0000, 1, 0, 4'b1111, 0, 1, 16'h0000);
        vecs[2]  = mk(4'b0110, 1, 1, 4'b0010, 1, 1, 4'b1111, 0, 1, 16'h0000);
        vecs[3]  = mk(4'b0110, 1, 1, 4'b0010, 1, 0, 4'b0111, 0, 1, 16'h0000);
        vecs[4]  = mk(4'b0000, 1, 1, 4'b0010, 1, 0, 4'b0110, 0, 1, 16'h0000);
        vecs[5]  = mk(4'b0000, 1, 1, 4'b0010, 1, 0, 4'b1111, 1, 1, 16'h0002);
        vecs[6]  = mk(4'b0000, 1, 1, 4'b0000, 0, 0, 4'b1111, 0, 1, 16'h0000);
        vecs[7]  = mk(4'b0000, 0, 1, 4'b0000, 0, 0, 4'b1111, 0, 1, 16'h0000);
        // B: ch2 type 10 block, wc=2 -> three transfers, TC on the third
        vecs[8]  = mk(4'b0100, 0, 1, 4'b0000, 1, 0, 4'b1111, 0, 1, 16'h0000);
        vecs[9]  = mk(4'b0100, 1, 1, 4'b0100, 1, 1, 4'b1111, 0, 1, 16'h0000);
        vecs[10] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1101, 0, 1, 16'h0000);
        vecs[11] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[12] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1111, 1, 1, 16'h0001);
        vecs[13] = mk(4'b0100, 1, 1, 4'b0100, 1, 1, 4'b1111, 0, 1, 16'h0000);
        vecs[14] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1101, 0, 1, 16'h0000);
        vecs[15] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[16] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1111, 1, 1, 16'h0000);
        vecs[17] = mk(4'b0100, 1, 1, 4'b0100, 1, 1, 4'b1111, 0, 1, 16'h0000);
        vecs[18] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1101, 0, 1, 16'h0000);
        vecs[19] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[20] = mk(4'b0100, 1, 1, 4'b0100, 1, 0, 4'b1111, 1, 0, 16'hFFFF);
        vecs[21] = mk(4'b0000, 1, 1, 4'b0000, 0, 0, 4'b1111, 0, 1, 16'h0000);
        // C: compressed, ch0 type 10, ready low for three wait states
        vecs[22] = mk(4'b0001, 0, 1, 4'b0000, 1, 0, 4'b1111, 0, 1, 16'h0000);
        vecs[23] = mk(4'b0001, 1, 1, 4'b0001, 1, 1, 4'b1111, 0, 1, 16'h0000);
        vecs[24] = mk(4'b0001, 1, 0, 4'b0001, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[25] = mk(4'b0000, 1, 0, 4'b0001, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[26] = mk(4'b0000, 1, 0, 4'b0001, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[27] = mk(4'b0000, 1, 0, 4'b0001, 1, 0, 4'b1001, 0, 1, 16'h0000);
        vecs[28] = mk(4'b0000, 1, 1, 4'b0001, 1, 0, 4'b1111, 1, 1, 16'h0004);
        vecs[29] = mk(4'b0000, 1, 1, 4'b0000, 0, 0, 4'b1111, 0, 1, 16'h0000);

        rst = 1'b1; dreq = '0; hlda = 1'b0; ready = 1'b1; eopNIn = 1'b1;
        chanMask = '0; chanBlock = '0; chanType = '0; wcLoad = '0;
        cmdDisable = 1'b0; cmdRotPri = 1'b0; cmdCompress = 1'b0; cmdExtWr = 1'b0;
        #2;
        check("reset_outputs",
              32'({hrq, dack, aen, adstb, iorN, iowN, memrN, memwN, eopNOut, adrStep, wcWb, tcStatus}),
              32'({1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000}));
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chanType = 8'b00_00_01_00; chanBlock = 4'b0000; wcLoad = 64'h0000_0000_0003_0000;
        runVecs(0, 7);

        doReset();
        chanType = 8'b00_10_00_00; chanBlock = 4'b0100; wcLoad = 64'h0000_0002_0000_0000;
        runVecs(8, 21);
        check("tc_status_block", 32'(tcStatus), 32'(4'b0100));

        doReset();
        chanType = 8'b00_00_00_10; chanBlock = 4'b0000; wcLoad = 64'h0000_0000_0000_0005;
        cmdCompress = 1'b1;
        runVecs(22, 29);

        // Masked and disabled requests never raise hrq
        doReset();
        chanMask = 4'b0001; dreq = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("masked_no_hrq", 32'(hrq), 32'(0));
        chanMask = 4'b0000; cmdDisable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("disabled_no_hrq", 32'(hrq), 32'(0));
        cmdDisable = 1'b0; dreq = '0;

        // Rotating priority: 1, then 0, then 1
        doReset();
        cmdRotPri = 1'b1; chanType = '0; chanBlock = '0; wcLoad = '0;
        dreq = 4'b0010;
        waitFor("rot_hrq1", 0); hlda = 1'b1;
        waitFor("rot_dack1", 1);
        check("rot_first", 32'(dack), 32'(4'b0010));
        dreq = 4'b0011;
        waitFor("rot_end1", 2); hlda = 1'b0;
        waitFor("rot_hrq2", 0); hlda = 1'b1;
        waitFor("rot_dack2", 1);
        check("rot_second", 32'(dack), 32'(4'b0001));
        waitFor("rot_end2", 2); hlda = 1'b0;
        waitFor("rot_hrq3", 0); hlda = 1'b1;
        waitFor("rot_dack3", 1);
        check("rot_third", 32'(dack), 32'(4'b0010));
        dreq = '0;
        waitFor("rot_end3", 2); hlda = 1'b0;
        check("rot_tc_status", 32'(tcStatus), 32'(4'b0011));

        // External EOP in S3 of a block transfer ends it without TC
        doReset();
        chanType = 8'b01_00_00_00; chanBlock = 4'b1000; wcLoad = 64'h0005_0000_0000_0000;
        dreq = 4'b1000;
        waitFor("eop_hrq", 0); hlda = 1'b1;
        waitFor("eop_s3", 3);
        eopNIn = 1'b0;
        @(posedge clk); #1;
        check("eop_s4_wb", 32'({wcWb, adrStep, eopNOut, wcWbCh, wcWbVal}),
              32'({1'b1, 1'b1, 1'b1, 2'd3, 16'h0004}));
        eopNIn = 1'b1;
        @(posedge clk); #1;
        check("eop_released", 32'({hrq, dack}), 32'(0));
        check("eop_no_tc", 32'(tcStatus), 32'(0));
        dreq = '0; hlda = 1'b0;

        // hlda lost in S2: strobes drop at once, no write-back
        doReset();
        chanType = 8'b00_00_00_10; chanBlock = 4'b0000; wcLoad = 64'h0000_0000_0000_0003;
        dreq = 4'b0001;
        waitFor("abort_hrq", 0); hlda = 1'b1;
        waitFor("abort_s2", 4);
        hlda = 1'b0;
        #1;
        check("abort_strobes", 32'({iorN, iowN, memrN, memwN, wcWb, adrStep}),
              32'({4'b1111, 1'b0, 1'b0}));
        @(posedge clk); #1;
        check("abort_si", 32'({hrq, dack, wcWb, adrStep}), 32'(0));

        // Async reset in S3
        waitFor("rst_hrq", 0); hlda = 1'b1;
        waitFor("rst_s3", 5);
        #2 rst = 1'b1;
        #1;
        check("async_reset",
              32'({hrq, dack, aen, adstb, iorN, iowN, memrN, memwN, eopNOut, adrStep, wcWb, tcStatus}),
              32'({1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000}));
        #1 rst = 1'b0; dreq = '0; hlda = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
